// File: rtl/seq_subtractor_if.sv
// Operand/result bundle for seq_subtractor: start/busy/done handshake plus data.
// The master side drives operands; the slave side (the subtractor) returns results.
interface seq_subtractor_if #(
  parameter int unsigned SIZE = 32
);
  logic            start;
  logic [SIZE-1:0] A;
  logic [SIZE-1:0] B;
  logic            Bin;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] Result;
  logic            Bout;
  logic            Overflow;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Result, Bout, Overflow
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Result, Bout, Overflow
  );
endinterface

// File: rtl/seq_subtractor.sv
// Multi-cycle A - B - Bin, CHUNK bits per clock with a registered borrow between chunks.
// Define SEQ_SUBTRACTOR_OVERFLOW_EN to build the signed overflow flag; otherwise it is tied to 0.
module seq_subtractor #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic              clk,
  input logic              rst_n,
  seq_subtractor_if.slave  bus
);
  localparam int unsigned N    = SIZE / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [SIZE-1:0]   a_q, a_d;
  logic [SIZE-1:0]   b_q, b_d;
  logic [SIZE-1:0]   result_q, result_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic              bout_q, bout_d;

  logic              accept;
  logic              last;
  logic              run_last;
  int unsigned       idx;
  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK:0]    diff;

  assign accept   = bus.start && (state_q != StRun);
  assign last     = (cnt_q == CntW'(N - 1));
  assign run_last = (state_q == StRun) && last;
  assign idx      = int'(cnt_q) * CHUNK;
  assign a_chunk  = a_q[idx +: CHUNK];
  assign b_chunk  = b_q[idx +: CHUNK];
  // Subtraction as A + ~B + ~borrow; the carry out is the inverted borrow.
  assign diff     = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK{1'b0}}, ~borrow_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d  = StRun;
          a_d      = bus.A;
          b_d      = bus.B;
          borrow_d = bus.Bin;
          cnt_d    = '0;
          result_d = '0;
          bout_d   = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        result_d[idx +: CHUNK] = diff[CHUNK-1:0];
        borrow_d               = ~diff[CHUNK];
        if (last) begin
          bout_d  = ~diff[CHUNK];
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

`ifdef SEQ_SUBTRACTOR_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // On the last chunk diff[CHUNK-1] is the result sign bit.
  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if (run_last) begin
      ovf_d = (a_q[SIZE-1] != b_q[SIZE-1]) && (diff[CHUNK-1] != a_q[SIZE-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.Overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf   = accept ^ run_last;
  assign bus.Overflow = 1'b0;
`endif

  assign bus.busy   = (state_q == StRun);
  assign bus.done   = (state_q == StDone);
  assign bus.Result = result_q;
  assign bus.Bout   = bout_q;
endmodule

// File: tb/tb_seq_subtractor.sv
// Self-checking bench for seq_subtractor: vector table, random ops and handshake/reset corners.
module tb_seq_subtractor;
  localparam int unsigned SIZE  = 32;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned N     = SIZE / CHUNK;
`ifdef SEQ_SUBTRACTOR_OVERFLOW_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] r;
    logic        bout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        bout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   start_cyc;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  seq_subtractor_if #(.SIZE(SIZE)) bif ();

  seq_subtractor #(.SIZE(SIZE), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] full;
    exp_t e;
    full   = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    e.r    = full[31:0];
    e.bout = full[32];
    e.ovf  = OvfEn && (a[31] != b[31]) && (full[31] != a[31]);
    return e;
  endfunction

  // Drive start for one accepting edge; sync=0 drives in the current (negedge) slot.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input bit sync, input bit push, input exp_t e);
    if (sync) @(negedge clk);
    bif.A     = a;
    bif.B     = b;
    bif.Bin   = bin;
    bif.start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    bif.start = 1'b0;
    chk("busy_after_accept", {31'd0, bif.busy}, 32'd1);
    if (push) sb_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      if (got) begin
        chk({tag, "_latency"}, 32'(cyc - start_cyc), N);
        chk({tag, "_busy_at_done"}, {31'd0, bif.busy}, 32'd0);
        chk({tag, "_result"}, bif.Result, e.r);
        chk({tag, "_bout"}, {31'd0, bif.Bout}, {31'd0, e.bout});
        chk({tag, "_ovf"}, {31'd0, bif.Overflow}, {31'd0, e.ovf});
      end
    end
  endtask

  task automatic after_done(input string tag, input logic [31:0] r);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, bif.done}, 32'd0);
    chk({tag, "_result_held"}, bif.Result, r);
  endtask

  vec_t vecs[9];
  exp_t e;
  bit   saw_done;

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    start_cyc = 0;
    rst_n     = 1'b0;
    bif.start = 1'b0;
    bif.A     = '0;
    bif.B     = '0;
    bif.Bin   = 1'b0;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[4] = '{32'h0100_0000, 32'h0000_0001, 1'b0, 32'h00FF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[8] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0};

    #12;
    chk("rst_busy", {31'd0, bif.busy}, 32'd0);
    chk("rst_done", {31'd0, bif.done}, 32'd0);
    chk("rst_result", bif.Result, 32'd0);
    chk("rst_bout", {31'd0, bif.Bout}, 32'd0);
    chk("rst_ovf", {31'd0, bif.Overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      e.r    = vecs[i].r;
      e.bout = vecs[i].bout;
      e.ovf  = vecs[i].ovf & OvfEn;
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b1, 1'b1, e);
      wait_done($sformatf("vec%0d", i));
      after_done($sformatf("vec%0d", i), vecs[i].r);
    end

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      logic        rbin;
      ra   = $urandom;
      rb   = $urandom;
      rbin = 1'($urandom_range(0, 1));
      e    = model(ra, rb, rbin);
      start_op(ra, rb, rbin, 1'b1, 1'b1, e);
      wait_done($sformatf("rnd%0d", i));
    end

    // start pulsed mid-RUN with different operands must be ignored
    e = '{32'h0000_0FFF, 1'b0, 1'b0};
    start_op(32'h0000_1000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, e);
    @(negedge clk);
    bif.A     = 32'hAAAA_AAAA;
    bif.B     = 32'h5555_5555;
    bif.Bin   = 1'b1;
    bif.start = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    wait_done("midrun");

    // start held in the DONE cycle is accepted back-to-back
    e = '{32'h0000_000F, 1'b0, 1'b0};
    start_op(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b0, 1'b1, e);
    wait_done("b2b");
    after_done("b2b", 32'h0000_000F);

    // async reset asserted between edges in the third RUN cycle
    start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, e);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bif.busy}, 32'd0);
    chk("arst_done", {31'd0, bif.done}, 32'd0);
    chk("arst_result", bif.Result, 32'd0);
    chk("arst_bout", {31'd0, bif.Bout}, 32'd0);
    chk("arst_ovf", {31'd0, bif.Overflow}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bif.done !== 1'b0) saw_done = 1'b1;
    end
    chk("arst_no_done", {31'd0, saw_done}, 32'd0);

    e = '{32'h0000_0002, 1'b0, 1'b0};
    start_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 1'b1, e);
    wait_done("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
